regfile_wb_arbiter: RTL and testbench

- Write-back arbiter that shares the register file's two write ports (wn1/d1/we1, wn2/d2/we2) among NREQ functional-unit result streams.
- Each cycle it grants up to two requesters, round-robin fair, and never grants two writes to the same register in one cycle. The register file's same-destination collision path is therefore never exercised.
- Write-port outputs are registered, which gives one cycle from grant to write strobe.
- Sits between the VLIW FP execution units and the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_if.sv | 35 +++
 rtl/regfile_wb_arbiter_rr_pick2.sv | 60 ++++++
 rtl/regfile_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   AW_DEF / DW_DEF : default register address and data widths
//   NREQ_MAX        : largest supported requester count
//   idx_t           : requester index, wide enough for NREQ_MAX
//   rr_next()       : (ptr + idx) mod nreq without a divider
package wb_pkg;

    localparam int unsigned AW_DEF   = 4;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned IDXW     = $clog2(NREQ_MAX);

    typedef logic [IDXW-1:0] idx_t;

    // Callers guarantee ptr < nreq and idx <= nreq, so one conditional subtract
    // is enough to wrap.
    function automatic idx_t rr_next(idx_t ptr, int unsigned idx, int unsigned nreq);
        int unsigned s;
        s = 32'(ptr) + idx;
        if (s >= nreq) begin
            s = s - nreq;
        end
        return idx_t'(s);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the FP result streams / register file and the write-back arbiter.
//   req_valid/req_wn/req_d : per-requester result (slice i at [i*AW +: AW], [i*DW +: DW])
//   req_ready              : combinational grant back to each requester
//   wb_hold                : suppresses all grants for the cycle
//   we1/wn1/d1, we2/wn2/d2 : registered register-file write ports
// Modport master = requester/register-file side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = wb_pkg::DW_DEF,
    parameter int unsigned AW   = wb_pkg::AW_DEF
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_wn;
    logic [NREQ*DW-1:0] req_d;
    logic [NREQ-1:0]    req_ready;
    logic               wb_hold;
    logic               we1;
    logic [AW-1:0]      wn1;
    logic [DW-1:0]      d1;
    logic               we2;
    logic [AW-1:0]      wn2;
    logic [DW-1:0]      d2;

    modport master (
        output req_valid, req_wn, req_d, wb_hold,
        input  req_ready, we1, wn1, d1, we2, wn2, d2
    );

    modport slave (
        input  req_valid, req_wn, req_d, wb_hold,
        output req_ready, we1, wn1, d1, we2, wn2, d2
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational two-winner round-robin selector.
//   valid : per-requester pending flag
//   wn    : per-requester destination register, slice i = [i*AW +: AW]
//   ptr   : first index to scan
//   a/has_a : first valid index in scan order
//   b/has_b : next valid index after a whose destination differs from a's
module rr_pick2
    import wb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic [NREQ-1:0]    valid,
    input  logic [NREQ*AW-1:0] wn,
    input  idx_t               ptr,
    output idx_t               a,
    output idx_t               b,
    output logic               has_a,
    output logic               has_b
);

    idx_t          scan;
    logic          scan_v;
    logic [AW-1:0] scan_wn;
    logic [AW-1:0] wn_a;

    always_comb begin
        a       = '0;
        b       = '0;
        has_a   = 1'b0;
        has_b   = 1'b0;
        wn_a    = '0;
        scan    = '0;
        scan_v  = 1'b0;
        scan_wn = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan    = rr_next(ptr, k, NREQ);
            scan_v  = 1'b0;
            scan_wn = '0;
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (scan == idx_t'(j)) begin
                    scan_v  = valid[j];
                    scan_wn = wn[j*AW +: AW];
                end
            end
            if (scan_v) begin
                if (!has_a) begin
                    has_a = 1'b1;
                    a     = scan;
                    wn_a  = scan_wn;
                end else if (!has_b && (scan_wn != wn_a)) begin
                    // Same-destination requesters are skipped, not blocking
                    has_b = 1'b1;
                    b     = scan;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the register file's two write ports among NREQ
// functional-unit result streams. Up to two grants per cycle, round-robin,
// never two writes to the same register in one cycle. Write ports are
// registered (grant in cycle N, write strobe in cycle N+1).
// Ports:
//   clk  : rising-edge clock
//   nClr : asynchronous active-low reset
//   bus  : regfile_wb_arbiter_if.slave (requests, ready, wb_hold, write ports)
// Optional (macro WB_SCOREBOARD_EN):
//   iss_valid/iss_wn : issue marks a destination register busy
//   busy             : per-register pending-write flags, cleared on write-back
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic                clk,
    input  logic                nClr,
    regfile_wb_arbiter_if.slave bus
`ifdef WB_SCOREBOARD_EN
    ,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_wn,
    output logic [2**AW-1:0]    busy
`endif
);

    idx_t          pick_a, pick_b;
    logic          has_a, has_b;
    logic          grant_a, grant_b;
    logic [AW-1:0] wn_a, wn_b;
    logic [DW-1:0] d_a, d_b;
    logic [NREQ-1:0] ready;
    idx_t          last;

    logic          we1_q, we1_d, we2_q, we2_d;
    logic [AW-1:0] wn1_q, wn1_d, wn2_q, wn2_d;
    logic [DW-1:0] d1_q, d1_d, d2_q, d2_d;
    idx_t          rr_ptr_q, rr_ptr_d;

    rr_pick2 #(
        .NREQ (NREQ),
        .AW   (AW)
    ) u_pick (
        .valid (bus.req_valid),
        .wn    (bus.req_wn),
        .ptr   (rr_ptr_q),
        .a     (pick_a),
        .b     (pick_b),
        .has_a (has_a),
        .has_b (has_b)
    );

    assign grant_a = has_a & ~bus.wb_hold;
    assign grant_b = has_b & ~bus.wb_hold;

    // Route winners' address/data onto the two ports
    always_comb begin
        wn_a = '0;
        d_a  = '0;
        wn_b = '0;
        d_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_a == idx_t'(i)) begin
                wn_a = bus.req_wn[i*AW +: AW];
                d_a  = bus.req_d[i*DW +: DW];
            end
            if (pick_b == idx_t'(i)) begin
                wn_b = bus.req_wn[i*AW +: AW];
                d_b  = bus.req_d[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if ((grant_a && (pick_a == idx_t'(i))) || (grant_b && (pick_b == idx_t'(i)))) begin
                ready[i] = 1'b1;
            end
        end
    end

    assign bus.req_ready = ready;

    always_comb begin
        we1_d    = grant_a;
        wn1_d    = grant_a ? wn_a : wn1_q;
        d1_d     = grant_a ? d_a  : d1_q;
        we2_d    = grant_b;
        wn2_d    = grant_b ? wn_b : wn2_q;
        d2_d     = grant_b ? d_b  : d2_q;
        // b only exists alongside a, so grant_a covers every grant cycle
        last     = grant_b ? pick_b : pick_a;
        rr_ptr_d = rr_ptr_q;
        if (grant_a) begin
            rr_ptr_d = rr_next(last, 1, NREQ);
        end
    end

    always_ff @(posedge clk or negedge nClr) begin
        if (!nClr) begin
            we1_q    <= 1'b0;
            wn1_q    <= '0;
            d1_q     <= '0;
            we2_q    <= 1'b0;
            wn2_q    <= '0;
            d2_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            we1_q    <= we1_d;
            wn1_q    <= wn1_d;
            d1_q     <= d1_d;
            we2_q    <= we2_d;
            wn2_q    <= wn2_d;
            d2_q     <= d2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.we1 = we1_q;
    assign bus.wn1 = wn1_q;
    assign bus.d1  = d1_q;
    assign bus.we2 = we2_q;
    assign bus.wn2 = wn2_q;
    assign bus.d2  = d2_q;

`ifdef WB_SCOREBOARD_EN
    logic [2**AW-1:0] busy_q, busy_d;

    // Clears come from the write strobes now on the ports; a same-cycle issue
    // to the same register is applied last so the set wins.
    always_comb begin
        busy_d = busy_q;
        if (we1_q) begin
            busy_d[wn1_q] = 1'b0;
        end
        if (we2_q) begin
            busy_d[wn2_q] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_wn] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nClr) begin
        if (!nClr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=4, DW=32, AW=4).
// Expected write-port values are queued when a grant cycle is driven and
// compared after the following rising edge. Define WB_SCOREBOARD_EN to also
// exercise the busy-register tracking.
module tb_regfile_wb_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;

    typedef struct packed {
        logic          we1;
        logic [AW-1:0] wn1;
        logic [DW-1:0] d1;
        logic          we2;
        logic [AW-1:0] wn2;
        logic [DW-1:0] d2;
    } exp_t;

    logic clk;
    logic nClr;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

`ifdef WB_SCOREBOARD_EN
    logic          iss_valid;
    logic [AW-1:0] iss_wn;
    logic [15:0]   busy;
`endif

    regfile_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) wb ();

    regfile_wb_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk  (clk),
        .nClr (nClr),
        .bus  (wb)
`ifdef WB_SCOREBOARD_EN
        ,
        .iss_valid (iss_valid),
        .iss_wn    (iss_wn),
        .busy      (busy)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed time limit reached, required $finish before it");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic we1, input logic [AW-1:0] wn1, input logic [DW-1:0] d1,
                                input logic we2, input logic [AW-1:0] wn2,
                                input logic [DW-1:0] d2);
        exp_t e;
        e.we1 = we1;
        e.wn1 = wn1;
        e.d1  = d1;
        e.we2 = we2;
        e.wn2 = wn2;
        e.d2  = d2;
        return e;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] wn, input logic [DW-1:0] d);
        wb.req_wn[i*AW +: AW] = wn;
        wb.req_d[i*DW +: DW]  = d;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed 0 queued entries expected 1", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".we1"}, 64'(wb.we1), 64'(e.we1));
            if (e.we1) begin
                chk({tag, ".wn1"}, 64'(wb.wn1), 64'(e.wn1));
                chk({tag, ".d1"}, 64'(wb.d1), 64'(e.d1));
            end
            chk({tag, ".we2"}, 64'(wb.we2), 64'(e.we2));
            if (e.we2) begin
                chk({tag, ".wn2"}, 64'(wb.wn2), 64'(e.wn2));
                chk({tag, ".d2"}, 64'(wb.d2), 64'(e.d2));
            end
        end
    endtask

    // Inputs are set by the caller just after a rising edge.
    task automatic tick(input string tag, input logic [NREQ-1:0] exp_ready, input exp_t exp_wr);
        @(negedge clk);
        chk({tag, ".ready"}, 64'(wb.req_ready), 64'(exp_ready));
        exp_q.push_back(exp_wr);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic chk_ptr(input string tag, input int unsigned expv);
        chk({tag, ".ptr"}, 64'(dut.rr_ptr_q), 64'(expv));
    endtask

    initial begin
        clk          = 1'b0;
        nClr         = 1'b1;
        n_checks     = 0;
        n_errors     = 0;
        wb.req_valid = '0;
        wb.req_wn    = '0;
        wb.req_d     = '0;
        wb.wb_hold   = 1'b0;
`ifdef WB_SCOREBOARD_EN
        iss_valid    = 1'b0;
        iss_wn       = '0;
`endif
        #1 nClr = 1'b0;
        #2;
        chk("rst.we1", 64'(wb.we1), 64'(0));
        chk("rst.we2", 64'(wb.we2), 64'(0));
        chk("rst.wn1", 64'(wb.wn1), 64'(0));
        chk("rst.wn2", 64'(wb.wn2), 64'(0));
        chk("rst.d1", 64'(wb.d1), 64'(0));
        chk("rst.d2", 64'(wb.d2), 64'(0));
        chk("rst.ready", 64'(wb.req_ready), 64'(0));
        chk_ptr("rst", 0);
`ifdef WB_SCOREBOARD_EN
        chk("rst.busy", 64'(busy), 64'(0));
`endif
        @(negedge clk);
        #2 nClr = 1'b1;
        @(posedge clk);
        #1;

        tick("idle", 4'b0000, mk(0, 0, 0, 0, 0, 0));
        chk_ptr("idle", 0);

        // Two requests to different registers
        set_req(0, 4'd3, 32'hA000_0003);
        set_req(1, 4'd5, 32'hA000_0105);
        wb.req_valid = 4'b0011;
        tick("pair", 4'b0011, mk(1, 4'd3, 32'hA000_0003, 1, 4'd5, 32'hA000_0105));
        chk_ptr("pair", 2);

        // Lone requester 3: ptr must wrap to 0
        set_req(3, 4'd1, 32'hB000_0301);
        wb.req_valid = 4'b1000;
        tick("wrap3", 4'b1000, mk(1, 4'd1, 32'hB000_0301, 0, 0, 0));
        chk_ptr("wrap3", 0);

        // Same-destination conflict: only requester 0 this cycle
        set_req(0, 4'd7, 32'hC000_0007);
        set_req(2, 4'd7, 32'hC000_0207);
        wb.req_valid = 4'b0101;
        tick("conf_a", 4'b0001, mk(1, 4'd7, 32'hC000_0007, 0, 0, 0));
        chk_ptr("conf_a", 1);
        wb.req_valid = 4'b0100;
        tick("conf_b", 4'b0100, mk(1, 4'd7, 32'hC000_0207, 0, 0, 0));
        chk_ptr("conf_b", 3);

        set_req(3, 4'd2, 32'hB000_0302);
        wb.req_valid = 4'b1000;
        tick("rewind", 4'b1000, mk(1, 4'd2, 32'hB000_0302, 0, 0, 0));
        chk_ptr("rewind", 0);

        // All four valid, distinct destinations, held four cycles
        set_req(0, 4'd4, 32'hE000_0004);
        set_req(1, 4'd5, 32'hE000_0105);
        set_req(2, 4'd6, 32'hE000_0206);
        set_req(3, 4'd8, 32'hE000_0308);
        wb.req_valid = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            tick("fair01", 4'b0011, mk(1, 4'd4, 32'hE000_0004, 1, 4'd5, 32'hE000_0105));
            chk_ptr("fair01", 2);
            tick("fair23", 4'b1100, mk(1, 4'd6, 32'hE000_0206, 1, 4'd8, 32'hE000_0308));
            chk_ptr("fair23", 0);
        end

        // Hold: no grants, pointer and port address/data held
        wb.wb_hold = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick("hold", 4'b0000, mk(0, 0, 0, 0, 0, 0));
            chk_ptr("hold", 0);
        end
        chk("hold.wn1", 64'(wb.wn1), 64'(6));
        chk("hold.d1", 64'(wb.d1), 64'(32'hE000_0206));
        chk("hold.wn2", 64'(wb.wn2), 64'(8));
        chk("hold.d2", 64'(wb.d2), 64'(32'hE000_0308));
        wb.wb_hold = 1'b0;
        tick("unhold", 4'b0011, mk(1, 4'd4, 32'hE000_0004, 1, 4'd5, 32'hE000_0105));
        chk_ptr("unhold", 2);

        // Grant {2,3} then reset before the edge: nothing may be written
        @(negedge clk);
        chk("rstmid.ready", 64'(wb.req_ready), 64'(4'b1100));
        #1 nClr = 1'b0;
        #1;
        chk("rstmid.we1", 64'(wb.we1), 64'(0));
        chk("rstmid.we2", 64'(wb.we2), 64'(0));
        chk("rstmid.wn1", 64'(wb.wn1), 64'(0));
        chk("rstmid.d1", 64'(wb.d1), 64'(0));
        chk_ptr("rstmid", 0);
        @(posedge clk);
        #1;
        chk("nowrite.we1", 64'(wb.we1), 64'(0));
        chk("nowrite.we2", 64'(wb.we2), 64'(0));
        wb.req_valid = 4'b0000;
        @(negedge clk);
        #2 nClr = 1'b1;
        @(posedge clk);
        #1;
        tick("idle2", 4'b0000, mk(0, 0, 0, 0, 0, 0));
        chk_ptr("idle2", 0);

`ifdef WB_SCOREBOARD_EN
        iss_valid = 1'b1;
        iss_wn    = 4'd9;
        @(posedge clk);
        #1;
        iss_valid = 1'b0;
        chk("sb.issue", 64'(busy[9]), 64'(1));
        set_req(0, 4'd9, 32'hF000_0009);
        wb.req_valid = 4'b0001;
        tick("sb_wr", 4'b0001, mk(1, 4'd9, 32'hF000_0009, 0, 0, 0));
        chk("sb.pending", 64'(busy[9]), 64'(1));
        wb.req_valid = 4'b0000;
        tick("sb_idle", 4'b0000, mk(0, 0, 0, 0, 0, 0));
        chk("sb.retired", 64'(busy[9]), 64'(0));
        wb.req_valid = 4'b0001;
        tick("sb_wr2", 4'b0001, mk(1, 4'd9, 32'hF000_0009, 0, 0, 0));
        wb.req_valid = 4'b0000;
        iss_valid    = 1'b1;
        iss_wn       = 4'd9;
        tick("sb_both", 4'b0000, mk(0, 0, 0, 0, 0, 0));
        iss_valid = 1'b0;
        chk("sb.setwins", 64'(busy), 64'(16'h0200));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
